// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson phase decoder: index-width helper,
// the code decode function and the step classification enum.
package johnson_pkg;

    // Widest Johnson code the decode helper understands, and the width of the
    // index it returns (2*32 = 64 phases fits in 8 bits).
    localparam int JC_MAX_W = 32;
    localparam int JC_IDX_W = 8;

    // How a legal sample relates to the previously decoded phase.
    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_ADV,
        STEP_JUMP
    } step_t;

    typedef struct packed {
        logic                legal;
        logic [JC_IDX_W-1:0] idx;
    } jc_dec_t;

    // Width of a phase index for an n-bit Johnson counter (2n phases).
    function automatic int idx_width(input int n);
        return (2 * n <= 2) ? 1 : $clog2(2 * n);
    endfunction

    // Decode the low n bits of code. The first half of the sequence fills
    // with ones from the MSB (index = number of ones); the second half drains
    // them so the ones sit at the LSB end (index = 2n - number of ones).
    function automatic jc_dec_t jc_decode(input logic [JC_MAX_W-1:0] code, input int n);
        jc_dec_t r;
        int      ones;
        logic    from_msb;
        logic    ok;
        ones = 0;
        for (int i = 0; i < JC_MAX_W; i++) begin
            if (i < n && code[i]) begin
                ones++;
            end
        end
        from_msb = code[n-1] || (ones == 0);
        ok = 1'b1;
        for (int i = 0; i < JC_MAX_W; i++) begin
            if (i < n) begin
                if (from_msb) begin
                    if (code[i] != (i >= n - ones)) begin
                        ok = 1'b0;
                    end
                end else begin
                    if (code[i] != (i < ones)) begin
                        ok = 1'b0;
                    end
                end
            end
        end
        r.legal = ok;
        r.idx   = from_msb ? JC_IDX_W'(ones) : JC_IDX_W'(2 * n - ones);
        return r;
    endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Purely combinational legality check and phase-index decode of one
// Johnson code word.
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 3
) (
    input  logic [N-1:0]  jc_in,
    output logic          legal,
    output logic [IW-1:0] idx
);

    logic [JC_MAX_W-1:0] code_ext;
    jc_dec_t             dec;

    // Zero-extend the code and run the shared decode function on it.
    always_comb begin
        code_ext         = '0;
        code_ext[N-1:0]  = jc_in;
        dec              = jc_decode(code_ext, N);
        legal            = dec.legal;
        idx              = IW'(dec.idx);
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson phase decoder: registers each valid code sample, decodes it to a
// phase index and one-hot bus, checks continuity, counts rotations and
// tracks errors. Define JDEC_ERR_CNT_EN to build the saturating error
// counter; otherwise err_cnt is tied to zero.
module johnson_phase_decoder
    import johnson_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int CW = 8,
    localparam int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  jc_in,
    input  logic          jc_valid,
    input  logic          clr_err,
    output logic          out_valid,
    output logic [IW-1:0] phase_idx,
    output logic [2*N-1:0] phase_onehot,
    output logic          illegal,
    output logic          jump,
    output logic          wrap_pulse,
    output logic [CW-1:0] cycle_cnt,
    output logic          err_sticky,
    output logic [CW-1:0] err_cnt
);

    localparam int          P        = 2 * N;
    localparam logic [IW-1:0] LAST_IDX = IW'(P - 1);

    logic          dec_legal;
    logic [IW-1:0] dec_idx;

    // phase_idx_q only changes on legal samples, so it doubles as the
    // previous legal index used for the continuity check.
    logic           out_valid_q,  out_valid_d;
    logic [IW-1:0]  phase_idx_q,  phase_idx_d;
    logic [P-1:0]   onehot_q,     onehot_d;
    logic           illegal_q,    illegal_d;
    logic           jump_q,       jump_d;
    logic           wrap_q,       wrap_d;
    logic [CW-1:0]  cycle_cnt_q,  cycle_cnt_d;
    logic           err_sticky_q, err_sticky_d;
    logic           have_prev_q,  have_prev_d;

    logic [IW-1:0]  next_idx;
    logic           accept;
    logic           tracked;
    logic           err_event;
    step_t          step;

    johnson_code_check #(
        .N  (N),
        .IW (IW)
    ) u_code_check (
        .jc_in (jc_in),
        .legal (dec_legal),
        .idx   (dec_idx)
    );

    // Classify a legal sample against the previous phase.
    always_comb begin
        next_idx = (phase_idx_q == LAST_IDX) ? '0 : phase_idx_q + IW'(1);
        if (dec_idx == phase_idx_q) begin
            step = STEP_HOLD;
        end else if (dec_idx == next_idx) begin
            step = STEP_ADV;
        end else begin
            step = STEP_JUMP;
        end
    end

    // Next-state computation for all registered outputs and tracking state.
    always_comb begin
        accept    = jc_valid & dec_legal;
        tracked   = accept & have_prev_q;
        illegal_d = jc_valid & ~dec_legal;
        jump_d    = tracked & (step == STEP_JUMP);
        wrap_d    = tracked & (phase_idx_q == LAST_IDX) & (dec_idx == '0);
        err_event = illegal_d | jump_d;

        out_valid_d = jc_valid;
        phase_idx_d = accept ? dec_idx : phase_idx_q;
        have_prev_d = have_prev_q | accept;
        cycle_cnt_d = wrap_d ? cycle_cnt_q + CW'(1) : cycle_cnt_q;

        onehot_d = onehot_q;
        if (jc_valid) begin
            onehot_d = '0;
            if (dec_legal) begin
                onehot_d[dec_idx] = 1'b1;
            end
        end

        err_sticky_d = err_sticky_q;
        if (err_event) begin
            err_sticky_d = 1'b1;
        end else if (clr_err) begin
            err_sticky_d = 1'b0;
        end
    end

    // Sample registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            phase_idx_q  <= '0;
            onehot_q     <= '0;
            illegal_q    <= 1'b0;
            jump_q       <= 1'b0;
            wrap_q       <= 1'b0;
            cycle_cnt_q  <= '0;
            err_sticky_q <= 1'b0;
            have_prev_q  <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            phase_idx_q  <= phase_idx_d;
            onehot_q     <= onehot_d;
            illegal_q    <= illegal_d;
            jump_q       <= jump_d;
            wrap_q       <= wrap_d;
            cycle_cnt_q  <= cycle_cnt_d;
            err_sticky_q <= err_sticky_d;
            have_prev_q  <= have_prev_d;
        end
    end

`ifdef JDEC_ERR_CNT_EN
    logic [CW-1:0] err_cnt_q, err_cnt_d;

    // Saturating error count; a new event in a clearing cycle restarts at 1.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_event) begin
            if (clr_err) begin
                err_cnt_d = CW'(1);
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + CW'(1);
            end
        end else if (clr_err) begin
            err_cnt_d = '0;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign out_valid    = out_valid_q;
    assign phase_idx    = phase_idx_q;
    assign phase_onehot = onehot_q;
    assign illegal      = illegal_q;
    assign jump         = jump_q;
    assign wrap_pulse   = wrap_q;
    assign cycle_cnt    = cycle_cnt_q;
    assign err_sticky   = err_sticky_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Testbench for johnson_phase_decoder: directed sequences plus random
// stimulus, checked by a queue-based scoreboard against a table-driven model.
module tb_johnson_phase_decoder;

   localparam int N  = 4;
   localparam int CW = 8;
   localparam int P  = 2 * N;
   localparam int IW = $clog2(P);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  jc_in = '0;
   logic          jc_valid = 1'b0;
   logic          clr_err = 1'b0;
   logic          out_valid;
   logic [IW-1:0] phase_idx;
   logic [P-1:0]  phase_onehot;
   logic          illegal;
   logic          jump;
   logic          wrap_pulse;
   logic [CW-1:0] cycle_cnt;
   logic          err_sticky;
   logic [CW-1:0] err_cnt;

   typedef struct {
      logic         ov;
      int           idx;
      logic [P-1:0] oh;
      logic         ill;
      logic         jmp;
      logic         wrp;
      int           cyc;
      logic         stk;
      int           ecnt;
   } exp_t;

   exp_t         expQ[$];
   logic [N-1:0] codeTable[P];

   bit           mHavePrev;
   int           mPrev;
   int           mCyc;
   bit           mStk;
   int           mEcnt;
   logic [P-1:0] mOh;

   int testsRun = 0;
   int testsFailed = 0;

   johnson_phase_decoder #(.N(N), .CW(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .jc_in        (jc_in),
      .jc_valid     (jc_valid),
      .clr_err      (clr_err),
      .out_valid    (out_valid),
      .phase_idx    (phase_idx),
      .phase_onehot (phase_onehot),
      .illegal      (illegal),
      .jump         (jump),
      .wrap_pulse   (wrap_pulse),
      .cycle_cnt    (cycle_cnt),
      .err_sticky   (err_sticky),
      .err_cnt      (err_cnt)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Single compare that keeps the counters and reports mismatches
   task automatic checkField(input string name, input int act, input int expv);
      testsRun++;
      if (act != expv) begin
         testsFailed++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
      end
   endtask

   // Compare every DUT output against one scoreboard entry
   task automatic checkOutput(input exp_t e);
      checkField("out_valid", int'(out_valid), int'(e.ov));
      checkField("phase_idx", int'(phase_idx), e.idx);
      checkField("phase_onehot", int'(phase_onehot), int'(e.oh));
      checkField("illegal", int'(illegal), int'(e.ill));
      checkField("jump", int'(jump), int'(e.jmp));
      checkField("wrap_pulse", int'(wrap_pulse), int'(e.wrp));
      checkField("cycle_cnt", int'(cycle_cnt), e.cyc);
      checkField("err_sticky", int'(err_sticky), int'(e.stk));
      checkField("err_cnt", int'(err_cnt), e.ecnt);
   endtask

   // Position of a code in the Johnson sequence, or -1 if not in it
   function automatic int findIdx(input logic [N-1:0] c);
      for (int i = 0; i < P; i++) begin
         if (codeTable[i] == c) return i;
      end
      return -1;
   endfunction

   function automatic void modelReset();
      mHavePrev = 0;
      mPrev = 0;
      mCyc = 0;
      mStk = 0;
      mEcnt = 0;
      mOh = '0;
   endfunction

   // Drive one cycle of inputs and push the response the model predicts
   task automatic applyStimulus(input bit v, input logic [N-1:0] c, input bit clr);
      exp_t e;
      int   k;
      bit   ev;
      @(negedge clk);
      #2;
      jc_valid = v;
      jc_in = c;
      clr_err = clr;
      e.ov = v;
      e.ill = 0;
      e.jmp = 0;
      e.wrp = 0;
      if (v) begin
         k = findIdx(c);
         if (k < 0) begin
            e.ill = 1;
            mOh = '0;
         end else begin
            if (mHavePrev && k != mPrev && k != (mPrev + 1) % P) e.jmp = 1;
            if (mHavePrev && mPrev == P - 1 && k == 0) begin
               e.wrp = 1;
               mCyc = (mCyc + 1) % (1 << CW);
            end
            mPrev = k;
            mHavePrev = 1;
            mOh = '0;
            mOh[k] = 1'b1;
         end
      end
      ev = e.ill | e.jmp;
      if (ev) mStk = 1;
      else if (clr) mStk = 0;
`ifdef JDEC_ERR_CNT_EN
      if (ev) begin
         if (clr) mEcnt = 1;
         else if (mEcnt != (1 << CW) - 1) mEcnt = mEcnt + 1;
      end else if (clr) begin
         mEcnt = 0;
      end
`endif
      e.idx = mPrev;
      e.oh = mOh;
      e.cyc = mCyc;
      e.stk = mStk;
      e.ecnt = mEcnt;
      expQ.push_back(e);
   endtask

   // Asynchronous reset in the middle of a cycle, checked while held
   task automatic resetDut();
      @(negedge clk);
      #2;
      jc_valid = 0;
      clr_err = 0;
      rst = 0;
      #1;
      checkField("rst_out_valid", int'(out_valid), 0);
      checkField("rst_phase_idx", int'(phase_idx), 0);
      checkField("rst_onehot", int'(phase_onehot), 0);
      checkField("rst_illegal", int'(illegal), 0);
      checkField("rst_jump", int'(jump), 0);
      checkField("rst_wrap", int'(wrap_pulse), 0);
      checkField("rst_cycle_cnt", int'(cycle_cnt), 0);
      checkField("rst_err_sticky", int'(err_sticky), 0);
      checkField("rst_err_cnt", int'(err_cnt), 0);
      modelReset();
      @(negedge clk);
      #2;
      rst = 1;
   endtask

   // Monitor: one scoreboard entry is due after every sampled edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   // Main stimulus sequence
   initial begin
      logic [N-1:0] q;
      int           r;
      logic [N-1:0] c;
      q = '0;
      for (int i = 0; i < P; i++) begin
         codeTable[i] = q;
         q = {~q[0], q[N-1:1]};
      end
      modelReset();

      #1;
      resetDut();

      // Full rotation plus return to zero
      for (int i = 0; i <= P; i++) applyStimulus(1, codeTable[i % P], 0);

      // Illegal code after phase 3, then 1111 continues without a jump
      for (int i = 1; i <= 3; i++) applyStimulus(1, codeTable[i], 0);
      applyStimulus(1, 4'b1010, 0);
      applyStimulus(1, 4'b1111, 0);

      // Out-of-order jump 1000 -> 0011
      applyStimulus(1, 4'b1000, 0);
      applyStimulus(1, 4'b0011, 0);

      // Repeated code with valid gaps
      applyStimulus(1, 4'b1100, 0);
      applyStimulus(0, 4'b0101, 0);
      applyStimulus(0, 4'b0000, 0);
      applyStimulus(1, 4'b1100, 0);
      applyStimulus(0, 4'b1111, 0);

      // Clear racing a jump, then a clear on its own
      applyStimulus(1, 4'b0001, 1);
      applyStimulus(0, 4'b0000, 1);

      // Reset mid-stream at phase 5, then a fresh start
      for (int i = 0; i <= 5; i++) applyStimulus(1, codeTable[i], 0);
      resetDut();
      applyStimulus(1, 4'b0000, 0);
      applyStimulus(1, 4'b1000, 0);

      // Long error run without clearing, exercising counter saturation
      for (int i = 0; i < 260; i++) applyStimulus(1, 4'b0100, 0);
      applyStimulus(1, 4'b0000, 1);

      // Enough rotations for the rotation counter to roll over
      for (int i = 1; i <= 257 * P; i++) applyStimulus(1, codeTable[i % P], 0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 60) c = codeTable[(mPrev + 1) % P];
         else if (r < 75) c = codeTable[mPrev];
         else if (r < 85) c = codeTable[$urandom_range(0, P - 1)];
         else c = N'($urandom);
         if ($urandom_range(0, 99) == 0) resetDut();
         applyStimulus($urandom_range(0, 3) != 0, c, $urandom_range(0, 9) == 0);
      end

      // Drain the scoreboard within a bounded number of cycles
      @(negedge clk);
      #2;
      jc_valid = 0;
      clr_err = 0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checkField("scoreboard_drain", expQ.size(), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
